// File: rtl/hcm_row_reader_if.sv
`default_nettype none
// ============================================================================
// hcm_row_reader_if : HCM read port plus row output stream of hcm_row_reader
// Rev 1.0
// ============================================================================
interface hcm_row_reader_if #(
  parameter int ROWINDEXBITS_HCM = 16,
  parameter int NCOLS_HCM        = 16
);
  logic                        readRow;
  logic [ROWINDEXBITS_HCM-1:0] inputRowToRead;
  logic                        hcmBusy;
  logic [ROWINDEXBITS_HCM-1:0] rowPassed;
  logic [NCOLS_HCM-1:0]        rowReadOutput;
  logic                        outValid;
  logic                        outReady;
  logic [ROWINDEXBITS_HCM-1:0] outRow;
  logic [NCOLS_HCM-1:0]        outData;

  modport master (
    output readRow, inputRowToRead, outValid, outRow, outData,
    input  hcmBusy, rowPassed, rowReadOutput, outReady
  );

  modport slave (
    input  readRow, inputRowToRead, outValid, outRow, outData,
    output hcmBusy, rowPassed, rowReadOutput, outReady
  );
endinterface
`default_nettype wire

// File: rtl/hcm_row_reader.sv
`default_nettype none
// ============================================================================
// hcm_row_reader : scans an HCM row range, buffers returned rows, streams them
// Optional macro HCM_READER_SKIP_EMPTY_EN drops all-zero rows.   Rev 1.0
// ============================================================================
module hcm_row_reader #(
  parameter int ROWINDEXBITS_HCM = 16,
  parameter int NCOLS_HCM        = 16,
  parameter int NROWS_HCM        = 65536,
  parameter int READ_LATENCY     = 2,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ROWINDEXBITS_HCM-1:0] firstRow,
  input  logic [ROWINDEXBITS_HCM-1:0] lastRow,
  output logic                        busy,
  output logic                        done,
  output logic                        addrError,
  hcm_row_reader_if.master            bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int INF_W = $clog2(READ_LATENCY + 1);
  localparam int SUM_W = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;
  localparam logic [ROWINDEXBITS_HCM-1:0] WRAP_ROW = ROWINDEXBITS_HCM'(NROWS_HCM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ROWINDEXBITS_HCM-1:0] cur_row;
  logic [ROWINDEXBITS_HCM-1:0] last_row;
  logic                        issue;
  logic                        credit_ok;
  logic [INF_W-1:0]            in_flight;

  logic                        tag_vld [READ_LATENCY];
  logic [ROWINDEXBITS_HCM-1:0] tag_row [READ_LATENCY];
  logic                        capture;
  logic [ROWINDEXBITS_HCM-1:0] cap_row;

  logic [ROWINDEXBITS_HCM-1:0] mem_row  [FIFO_DEPTH];
  logic [NCOLS_HCM-1:0]        mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [CNT_W-1:0]            fifo_count;
  logic                        fifo_valid;
  logic                        push;
  logic                        pop;

  // In-flight reads hold a FIFO slot, so the buffer cannot overflow under stall.
  assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(in_flight)) < SUM_W'(FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        busy = 1'b1;
        if (!bus.hcmBusy && credit_ok) begin
          issue = 1'b1;
          if (cur_row == last_row) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (in_flight == '0 && fifo_count == '0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.readRow        = issue;
  assign bus.inputRowToRead = cur_row;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_row  <= '0;
      last_row <= '0;
    end else if (state == IDLE && start) begin
      cur_row  <= firstRow;
      last_row <= lastRow;
    end else if (issue) begin
      cur_row <= (cur_row == WRAP_ROW) ? '0 : cur_row + 1'b1;
    end
  end

  // The tag pipeline mirrors the HCM latency so the issued row meets its data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_vld[i] <= 1'b0;
        tag_row[i] <= '0;
      end
    end else begin
      tag_vld[0] <= issue;
      tag_row[0] <= cur_row;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_row[i] <= tag_row[i-1];
      end
    end
  end

  assign capture = tag_vld[READ_LATENCY-1];
  assign cap_row = tag_row[READ_LATENCY-1];

`ifdef HCM_READER_SKIP_EMPTY_EN
  assign push = capture && (bus.rowReadOutput != '0);
`else
  assign push = capture;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      in_flight <= '0;
    end else begin
      case ({issue, capture})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addrError <= 1'b0;
    end else if (capture && (bus.rowPassed != cap_row)) begin
      addrError <= 1'b1;
    end
  end

  assign fifo_valid = (fifo_count != '0);
  assign pop        = fifo_valid && bus.outReady;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_row[wr_ptr]  <= cap_row;
      mem_data[wr_ptr] <= bus.rowReadOutput;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign bus.outValid = fifo_valid;
  assign bus.outRow   = fifo_valid ? mem_row[rd_ptr]  : '0;
  assign bus.outData  = fifo_valid ? mem_data[rd_ptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_hcm_row_reader.sv
`default_nettype none
// ============================================================================
// tb_hcm_row_reader : directed scans against a queue-based model of the reader
// ============================================================================
module tb_hcm_row_reader;
  localparam int RW    = 16;
  localparam int NC    = 16;
  localparam int NROWS = 65536;
  localparam int LAT   = 2;
  localparam int DEPTH = 8;
`ifdef HCM_READER_SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [RW-1:0] firstRow = '0;
  logic [RW-1:0] lastRow = '0;
  logic          busy, done, addrError;

  hcm_row_reader_if #(.ROWINDEXBITS_HCM(RW), .NCOLS_HCM(NC)) bus ();

  hcm_row_reader #(
    .ROWINDEXBITS_HCM(RW), .NCOLS_HCM(NC), .NROWS_HCM(NROWS),
    .READ_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .firstRow(firstRow), .lastRow(lastRow),
    .busy(busy), .done(done), .addrError(addrError), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // HCM memory content: row index, or a sparse pattern with only rows 3 and 8 set
  logic sparse_mode = 1'b0;
  logic corrupt_en  = 1'b0;
  logic [RW-1:0] corrupt_row = '0;

  function automatic logic [NC-1:0] hcm_word(input logic [RW-1:0] r, input logic sp);
    if (!sp) return NC'(r);
    if (r == 16'd3) return 16'hA003;
    if (r == 16'd8) return 16'hB008;
    return '0;
  endfunction

  logic [RW-1:0] hp_a [LAT];
  always @(posedge clk) begin
    hp_a[0] <= bus.inputRowToRead;
    for (int i = 1; i < LAT; i++) hp_a[i] <= hp_a[i-1];
  end

  always_comb begin
    bus.rowReadOutput = hcm_word(hp_a[LAT-1], sparse_mode);
    bus.rowPassed     = (corrupt_en && hp_a[LAT-1] == corrupt_row) ? (hp_a[LAT-1] ^ 16'd1) : hp_a[LAT-1];
  end

  // Model: expected issue addresses and expected output beats, in order
  logic [RW-1:0]    exp_issue [$];
  logic [RW+NC-1:0] exp_beat  [$];
  logic [RW-1:0]    got_rows  [$];
  int   issued = 0;
  int   popped = 0;
  int   done_cnt = 0;
  logic check_en = 1'b0;

  task automatic load_scan(input logic [RW-1:0] f, input logic [RW-1:0] l);
    logic [RW-1:0] r;
    r = f;
    for (int k = 0; k < NROWS; k++) begin
      exp_issue.push_back(r);
      if (!SKIP || hcm_word(r, sparse_mode) != '0) exp_beat.push_back({r, hcm_word(r, sparse_mode)});
      if (r == l) break;
      r = (int'(r) == NROWS - 1) ? '0 : r + 16'd1;
    end
  endtask

  initial begin : cmp
    logic [RW+NC-1:0] e;
    logic             prev_stall;
    logic [RW-1:0]    prev_row;
    logic [NC-1:0]    prev_data;
    prev_stall = 1'b0;
    prev_row   = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (check_en) begin
        if (bus.readRow) begin
          check("rd_while_hcmbusy", int'(bus.hcmBusy), 0);
          if (exp_issue.size() == 0) fail("issue_unexpected");
          else check("issue_addr", int'(bus.inputRowToRead), int'(exp_issue.pop_front()));
          issued++;
        end
        if (prev_stall) begin
          check("stall_valid", int'(bus.outValid), 1);
          check("stall_row", int'(bus.outRow), int'(prev_row));
          check("stall_data", int'(bus.outData), int'(prev_data));
        end
        if (bus.outValid && bus.outReady) begin
          if (exp_beat.size() == 0) fail("beat_unexpected");
          else begin
            e = exp_beat.pop_front();
            check("beat_row", int'(bus.outRow), int'(e[RW+NC-1:NC]));
            check("beat_data", int'(bus.outData), int'(e[NC-1:0]));
          end
          got_rows.push_back(bus.outRow);
          popped++;
        end
`ifndef HCM_READER_SKIP_EMPTY_EN
        check("credit_bound", int'(issued - popped <= DEPTH), 1);
`endif
        if (done) begin
          done_cnt++;
          check("done_early", exp_beat.size() + exp_issue.size(), 0);
        end
        prev_stall = bus.outValid && !bus.outReady;
        prev_row   = bus.outRow;
        prev_data  = bus.outData;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic run_scan(input logic [RW-1:0] f, input logic [RW-1:0] l,
                          input int stall_at, input int stall_len,
                          input int hb_at, input int hb_len,
                          output int first_rd, output int n_rd, output int last_rd,
                          output int first_valid, output int done_at);
    int cyc;
    int d0;
    load_scan(f, l);
    got_rows.delete();
    d0 = done_cnt;
    first_rd = -1; n_rd = 0; last_rd = -1; first_valid = -1; done_at = -1;
    @(posedge clk); #1;
    firstRow = f; lastRow = l; start = 1'b1;
    check("busy_before_start", int'(busy), 0);
    cyc = 0;
    while (cyc < 3000) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      bus.outReady = !(cyc >= stall_at && cyc < stall_at + stall_len);
      bus.hcmBusy  = (cyc >= hb_at && cyc < hb_at + hb_len);
      @(negedge clk);
      if (cyc == 1) check("busy_after_start", int'(busy), 1);
      if (bus.readRow) begin
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        n_rd++;
      end
      if (bus.outValid && first_valid < 0) first_valid = cyc;
      if (done) begin
        done_at = cyc;
        check("busy_in_done", int'(busy), 0);
        break;
      end
    end
    if (done_at < 0) fail("scan_timeout");
    @(posedge clk); #1;
    bus.outReady = 1'b1;
    bus.hcmBusy  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("done_once", done_cnt - d0, 1);
    check("issue_queue_empty", exp_issue.size(), 0);
    check("beat_queue_empty", exp_beat.size(), 0);
  endtask

  initial begin : drv
    int fr, nr, lr, fv, da, n;
    bus.outReady = 1'b1;
    bus.hcmBusy  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_readRow", int'(bus.readRow), 0);
    check("rst_outValid", int'(bus.outValid), 0);
    check("rst_addrError", int'(addrError), 0);
    check("rst_inputRowToRead", int'(bus.inputRowToRead), 0);
    check("rst_outRow", int'(bus.outRow), 0);
    check("rst_outData", int'(bus.outData), 0);
    reset = 1'b1;
    check_en = 1'b1;

    // Full-rate scan 0..49
    run_scan(16'd0, 16'd49, 0, 0, 0, 0, fr, nr, lr, fv, da);
    check("full_first_rd", fr, 1);
    check("full_n_rd", nr, 50);
    check("full_last_rd", lr, 50);
    check("full_done_at", da, 55);
    check("full_beats", got_rows.size(), SKIP ? 49 : 50);
`ifndef HCM_READER_SKIP_EMPTY_EN
    check("full_first_valid", fv, 4);
    if (got_rows.size() == 50) check("full_last_row", int'(got_rows[49]), 49);
`endif
    check("full_addrError", int'(addrError), 0);

    // Wrap scan 65534..1
    run_scan(16'd65534, 16'd1, 0, 0, 0, 0, fr, nr, lr, fv, da);
    check("wrap_n_rd", nr, 4);
    check("wrap_done_at", da, 9);
`ifndef HCM_READER_SKIP_EMPTY_EN
    check("wrap_beats", got_rows.size(), 4);
    if (got_rows.size() == 4) begin
      check("wrap_row0", int'(got_rows[0]), 65534);
      check("wrap_row1", int'(got_rows[1]), 65535);
      check("wrap_row2", int'(got_rows[2]), 0);
      check("wrap_row3", int'(got_rows[3]), 1);
    end
`endif

    // Backpressure plus hcmBusy window
    run_scan(16'd100, 16'd139, 12, 30, 5, 5, fr, nr, lr, fv, da);
    check("bp_n_rd", nr, 40);
    check("bp_beats", got_rows.size(), 40);
    if (got_rows.size() == 40) check("bp_last_row", int'(got_rows[39]), 139);

    // Returned row index mismatch sets sticky addrError
    corrupt_en  = 1'b1;
    corrupt_row = 16'd24;
    run_scan(16'd20, 16'd27, 0, 0, 0, 0, fr, nr, lr, fv, da);
    corrupt_en = 1'b0;
    check("addr_error_set", int'(addrError), 1);

    // Reset at the 10th issued read
    load_scan(16'd200, 16'd240);
    @(posedge clk); #1;
    firstRow = 16'd200; lastRow = 16'd240; start = 1'b1;
    n = 0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (bus.readRow) n++;
    end
    if (n < 10) fail("reset_wait_timeout");
    reset = 1'b0;
    @(posedge clk); #1;
    check_en = 1'b0;
    exp_issue.delete();
    exp_beat.delete();
    issued = 0;
    popped = 0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_outValid", int'(bus.outValid), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_addrError", int'(addrError), 0);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("postrst_outValid", int'(bus.outValid), 0);
      check("postrst_done", int'(done), 0);
    end
    check_en = 1'b1;
    run_scan(16'd7, 16'd7, 0, 0, 0, 0, fr, nr, lr, fv, da);
    check("single_n_rd", nr, 1);
    check("single_beats", got_rows.size(), 1);
    if (got_rows.size() == 1) check("single_row", int'(got_rows[0]), 7);

    // Sparse content rows 0..9: only rows 3 and 8 nonzero
    sparse_mode = 1'b1;
    repeat (LAT + 1) @(posedge clk);
    run_scan(16'd0, 16'd9, 0, 0, 0, 0, fr, nr, lr, fv, da);
    check("sparse_n_rd", nr, 10);
    check("sparse_beats", got_rows.size(), SKIP ? 2 : 10);
`ifdef HCM_READER_SKIP_EMPTY_EN
    if (got_rows.size() == 2) begin
      check("sparse_row_a", int'(got_rows[0]), 3);
      check("sparse_row_b", int'(got_rows[1]), 8);
    end
`else
    if (got_rows.size() == 10) check("sparse_row3", int'(got_rows[3]), 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/hcm_row_reader.md
Name: hcm_row_reader

Overview:
- Read-side master for the HCM: scans a programmable row range and issues one readRow request per cycle into the HCM read port.
- Captures the returned rowPassed/rowReadOutput pairs after the HCM's fixed read latency and buffers them in a small FIFO.
- Emits the buffered rows as a valid/ready stream toward downstream road-building logic.
- Replaces the ad-hoc "print BRAM" sequencing with a reusable, back-pressured block.

Parameters:
- ROWINDEXBITS_HCM, 16, width of the row index.
- NCOLS_HCM, 16, width of one HCM row word.
- NROWS_HCM, 65536, number of HCM rows; wrap point of the scan.
- READ_LATENCY, 2, cycles from readRow asserted to rowPassed/rowReadOutput valid at HCM outputs; legal range 1..8.
- FIFO_DEPTH, 8, output buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a scan; ignored while busy=1
- firstRow  in  ROWINDEXBITS_HCM  first row of scan, sampled on start
- lastRow  in  ROWINDEXBITS_HCM  last row of scan, inclusive, sampled on start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the last row has left the FIFO
- readRow  out  1  HCM read strobe
- inputRowToRead  out  ROWINDEXBITS_HCM  HCM read address
- hcmBusy  in  1  HCM busy; no readRow is issued while high
- rowPassed  in  ROWINDEXBITS_HCM  HCM returned row index
- rowReadOutput  in  NCOLS_HCM  HCM returned row word
- outValid  out  1  stream valid
- outReady  in  1  stream ready
- outRow  out  ROWINDEXBITS_HCM  row index of current beat
- outData  out  NCOLS_HCM  row word of current beat
- addrError  out  1  sticky; returned rowPassed differed from the issued address

Behaviour:
- Reset (reset=0 at a clk edge):
  - busy, done, readRow, outValid and addrError all go to 0.
  - inputRowToRead, outRow and outData go to 0.
  - FIFO is emptied, the in-flight tag pipeline is cleared, and the FSM enters IDLE.
  - Reset mid-scan abandons the scan: no done pulse, and late HCM returns are dropped.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: on start, latch firstRow/lastRow, set curRow=firstRow, go to ISSUE; busy=1 from the next cycle.
  - ISSUE: issue a read when hcmBusy=0 and (fifoCount + inFlight) < FIFO_DEPTH.
    - On issue, readRow=1 and inputRowToRead=curRow for one cycle, and the tag {1, curRow} enters a READ_LATENCY-deep shift pipeline.
    - Having issued curRow==lastRow, go to DRAIN; otherwise curRow increments.
  - DRAIN: wait until inFlight==0 and the FIFO is empty, then go to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE. A start in this cycle is ignored.
- Scan range and wrap:
  - curRow increments modulo NROWS_HCM.
  - If firstRow > lastRow the scan wraps: firstRow..NROWS_HCM-1, then 0..lastRow.
  - firstRow==lastRow reads exactly one row.
- Issue throughput:
  - One read per cycle at full rate.
  - Credit check counts in-flight reads, so the FIFO never overflows regardless of outReady.
- Capture:
  - When a tag exits the pipeline, push {tagRow, rowReadOutput} into the FIFO.
  - If rowPassed != tagRow, set addrError; it clears only on reset.
  - Push and pop in the same cycle are both allowed, even when the FIFO is full.
- Stream interface:
  - Beat transfers when outValid && outReady.
  - outRow/outData stay stable while outValid && !outReady.
  - Row order equals issue order.
- Counter widths:
  - fifoCount has log2(FIFO_DEPTH)+1 bits.
  - inFlight counts up to READ_LATENCY.

Optional Feature:
- Macro HCM_READER_SKIP_EMPTY_EN.
  - Defined: captured rows with rowReadOutput==0 are discarded, not pushed; the credit is released in the capture cycle. done still fires after the final row returns, even if nothing was emitted.
  - Undefined: every scanned row produces exactly one output beat.

Test Plan:
- Full-rate scan: firstRow=0, lastRow=49, outReady=1, HCM preloaded with row i = i.
  - 50 beats, outRow=0..49 in order, outData=outRow.
  - readRow high 50 consecutive cycles; done once; addrError=0.
- Wrap scan: firstRow=65534, lastRow=1.
  - Beats for rows 65534, 65535, 0, 1 only; done after the 4th pop.
- Backpressure: outReady=0 for 30 cycles mid-scan.
  - At most FIFO_DEPTH=8 rows buffered plus in-flight reads; no loss or duplication.
  - outRow/outData stable while stalled; resumes in order.
- hcmBusy: hcmBusy=1 for 5 cycles during ISSUE.
  - No readRow during those cycles; scan resumes at the next row; total beats unchanged.
- Reset mid-scan: reset=0 at the 10th issued read.
  - Next cycle busy=0, outValid=0, no done.
  - A new start with firstRow=lastRow=7 yields exactly one beat, row 7.
- Skip-empty (HCM_READER_SKIP_EMPTY_EN defined): rows 0..9 with only rows 3 and 8 nonzero.
  - Exactly 2 beats (3, 8), then done.
  - Same scan with the macro undefined gives 10 beats.
